// File: rtl/serial_parallel_sr_if.sv
// Bus bundle for serial_parallel_sr: serial input side (sync, data_in) and
// the parallel result side (data_out plus status strobes).
interface serial_parallel_sr_if #(
  parameter int INPUT_WIDTH = 8
);
  // No backpressure. data_valid is a single-cycle strobe that marks data_out
  // as freshly loaded, and data_out holds its value until the next strobe.
  // The upstream source must present one serial bit per cycle, with sync
  // coinciding with bit 0.
  logic                   sync;
  logic                   data_in;
  logic [INPUT_WIDTH-1:0] data_out;
  logic                   data_valid;
  logic                   busy;
  logic                   frame_abort;
  logic                   parity_err;

  modport master (
    output sync, data_in,
    input  data_out, data_valid, busy, frame_abort, parity_err
  );

  modport slave (
    input  sync, data_in,
    output data_out, data_valid, busy, frame_abort, parity_err
  );
endinterface

// File: rtl/serial_parallel_sr.sv
// LSB-first serial-to-parallel deserializer with frame restart detection.
// Define SERIAL_PARALLEL_SR_PARITY_EN to add a trailing even-parity bit per frame.
module serial_parallel_sr #(
  parameter int INPUT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_parallel_sr_if.slave     bus,
  output logic [1:0]              state_dbg
);

  localparam int CW = $clog2(INPUT_WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]             state_q;
  logic [CW-1:0]          cnt_q;
  logic [INPUT_WIDTH-1:0] shift_q;
  logic [INPUT_WIDTH-1:0] data_out_q;
  logic                   valid_q;
  logic                   abort_q;
  logic [INPUT_WIDTH-1:0] word_nxt;
  logic                   last_bit;

  // Shift register with the current serial bit merged in at position cnt_q.
  always_comb begin
    word_nxt = shift_q;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (cnt_q == CW'(i)) word_nxt[i] = bus.data_in;
    end
  end

  assign last_bit = (cnt_q == CW'(INPUT_WIDTH - 1));

`ifdef SERIAL_PARALLEL_SR_PARITY_EN
  logic perr_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      abort_q    <= 1'b0;
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      abort_q <= 1'b0;
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
      perr_q  <= 1'b0;
`endif
      if (bus.sync) begin
        // A start strobe always begins a new frame; outside IDLE it also
        // throws away the partial one.
        abort_q <= (state_q != S_IDLE);
        shift_q <= {{(INPUT_WIDTH-1){1'b0}}, bus.data_in};
        cnt_q   <= CW'(1);
        state_q <= S_SHIFT;
      end else begin
        case (state_q)
          S_SHIFT: begin
            shift_q <= word_nxt;
            if (last_bit) begin
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
              cnt_q   <= CW'(INPUT_WIDTH);
              state_q <= S_PARITY;
`else
              data_out_q <= word_nxt;
              valid_q    <= 1'b1;
              cnt_q      <= '0;
              state_q    <= S_IDLE;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
          S_PARITY: begin
            data_out_q <= shift_q;
            valid_q    <= 1'b1;
            perr_q     <= (^shift_q) ^ bus.data_in;
            cnt_q      <= '0;
            state_q    <= S_IDLE;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_abort = abort_q;
  assign bus.busy        = (state_q != S_IDLE);
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
  assign bus.parity_err  = perr_q;
`else
  assign bus.parity_err  = 1'b0;
`endif
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_serial_parallel_sr.sv
// Bench for serial_parallel_sr: vector table, directed corner sequences and
// random frames checked cycle by cycle against a bit-queue frame model.
module tb_serial_parallel_sr;

  localparam int W = 8;
`ifdef SERIAL_PARALLEL_SR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_LEN = W + (PAR_EN ? 1 : 0);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] state_dbg;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_parallel_sr_if #(.INPUT_WIDTH(W)) bus();

  serial_parallel_sr #(.INPUT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Collects the bits of the open frame in a queue; a frame completes when
  // the queue holds FRAME_LEN bits, and the word is rebuilt arithmetically.
  logic       bits[$];
  bit         in_frame = 1'b0;
  logic [W-1:0] m_out = '0;
  logic       m_valid = 1'b0;
  logic       m_abort = 1'b0;
  logic       m_perr  = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits.delete();
      in_frame = 1'b0;
      m_out = '0; m_valid = 1'b0; m_abort = 1'b0; m_perr = 1'b0;
    end else begin
      m_valid = 1'b0; m_abort = 1'b0; m_perr = 1'b0;
      if (bus.sync) begin
        if (in_frame) m_abort = 1'b1;
        bits.delete();
        bits.push_back(bus.data_in);
        in_frame = 1'b1;
      end else if (in_frame) begin
        bits.push_back(bus.data_in);
      end
      if (in_frame && bits.size() == FRAME_LEN) begin
        int word;
        int ones;
        word = 0;
        ones = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (bits[i] === 1'b1) begin
            ones++;
            if (i < W) word = word + (1 << i);
          end
        end
        m_out   = W'(word);
        m_valid = 1'b1;
        m_perr  = PAR_EN && (ones % 2 == 1);
        exp_q.push_back(W'(word));
        in_frame = 1'b0;
        bits.delete();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] got_q[$];
  int           got_t[$];
  logic         got_p[$];
  int           abort_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      check("cycle_outputs",
            {bus.data_out, bus.data_valid, bus.busy, bus.frame_abort, bus.parity_err},
            {m_out, m_valid, logic'(in_frame), m_abort, m_perr});
      if (bus.data_valid) begin
        got_q.push_back(bus.data_out);
        got_t.push_back(cyc);
        got_p.push_back(bus.parity_err);
        if (exp_q.size() == 0) check("sb_unexpected_word", bus.data_out, 64'hDEAD);
        else check("sb_word", bus.data_out, exp_q.pop_front());
      end
      if (bus.frame_abort) abort_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic s, input logic d);
    bus.sync = s;
    bus.data_in = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_bits(input logic [W-1:0] w, input logic pbit, input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(i == 0, (i < W) ? w[i] : pbit);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit);
    send_bits(w, pbit, FRAME_LEN);
  endtask

  task automatic clear_logs();
    got_q.delete(); got_t.delete(); got_p.delete();
    abort_cnt = 0;
  endtask

  function automatic logic even_par(input logic [W-1:0] w);
    return ^w;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] word;
    logic         pbit;
    logic [W-1:0] exp_out;
    logic         exp_perr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] held;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 8'h07, 1'b0};
    vecs[2] = '{8'h07, 1'b0, 8'h07, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b1};

    bus.sync = 1'b0;
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero",
          {bus.data_out, bus.data_valid, bus.busy, bus.frame_abort, bus.parity_err}, '0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy_after_reset", bus.busy, 1'b0);

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      send_frame(vecs[v].word, vecs[v].pbit);
      idle(2);
      check("vec_count", got_q.size(), 1);
      check("vec_data_out", (got_q.size() > 0) ? got_q[0] : 'x, vecs[v].exp_out);
      check("vec_parity_err", (got_p.size() > 0) ? got_p[0] : 1'bx,
            PAR_EN ? vecs[v].exp_perr : 1'b0);
    end

    // Held output after 0xA5
    clear_logs();
    send_frame(8'hA5, even_par(8'hA5));
    idle(6);
    check("a5_single_pulse", got_q.size(), 1);
    check("a5_held", bus.data_out, 8'hA5);

    // Back-to-back frames
    clear_logs();
    send_frame(8'h3C, even_par(8'h3C));
    send_frame(8'hC3, even_par(8'hC3));
    idle(3);
    check("b2b_count", got_q.size(), 2);
    check("b2b_first", (got_q.size() > 1) ? got_q[0] : 'x, 8'h3C);
    check("b2b_second", (got_q.size() > 1) ? got_q[1] : 'x, 8'hC3);
    check("b2b_spacing", (got_t.size() > 1) ? got_t[1] - got_t[0] : -1, FRAME_LEN);
    check("b2b_no_abort", abort_cnt, 0);

    // Abort after 4 bits of 0xFF
    clear_logs();
    send_bits(8'hFF, 1'b1, 4);
    send_frame(8'h12, even_par(8'h12));
    idle(3);
    check("abort_count", abort_cnt, 1);
    check("abort_words", got_q.size(), 1);
    check("abort_word", (got_q.size() > 0) ? got_q[0] : 'x, 8'h12);

    // Reset in the middle of a frame
    clear_logs();
    held = bus.data_out;
    check("pre_reset_nonzero", (held != '0), 1'b1);
    send_bits(8'hFF, 1'b1, 5);
    #2 reset = 1'b0;
    #1 check("midframe_reset_zero",
             {bus.data_out, bus.data_valid, bus.busy, bus.frame_abort, bus.parity_err}, '0);
    @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b0, 1'b1);
    check("post_reset_busy", bus.busy, 1'b0);
    send_frame(8'h81, even_par(8'h81));
    idle(3);
    check("rst_words", got_q.size(), 1);
    check("rst_word", (got_q.size() > 0) ? got_q[0] : 'x, 8'h81);
    check("rst_no_abort", abort_cnt, 0);

    // Randomized frames, gaps, truncations and parity bits
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] w;
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        w = W'($urandom);
        send_bits(w, 1'($urandom_range(0, 1)), $urandom_range(1, FRAME_LEN - 1));
      end
      w = W'($urandom);
      send_frame(w, ($urandom_range(0, 3) == 0) ? ~even_par(w) : even_par(w));
    end
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
